// File: rtl/fetch_queue.sv
// Fetch PC owner plus a DEPTH-entry {pc, instr} queue feeding decode.
// Optional same-cycle bypass when FETCH_QUEUE_BYPASS_EN is defined.
//
// Ports:
//   clock, reset             : clock, synchronous active-high reset
//   imem_addr/data/stall     : instruction memory request/response
//   redirect, redirect_pc    : flush and restart fetch at a target
//   d_stall                  : decode backpressure
//   d_valid, d_instr, d_pc   : head instruction to decode (0 when invalid)
//   q_count                  : registered queue occupancy
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_data,
    input  logic                       imem_stall,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       d_stall,
    output logic                       d_valid,
    output logic [31:0]                d_instr,
    output logic [31:0]                d_pc,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic mem_ok;
    logic q_empty;
    logic q_full;
    logic q_pop;
    logic accept;
    logic push;

    // An X stall must not let garbage into the queue.
    assign mem_ok  = (imem_stall === 1'b0);
    assign q_empty = (cnt == '0);
    assign q_full  = (cnt == CW'(DEPTH));

    // Queue-head pop; independent of accept, so no loop.
    assign q_pop   = !q_empty && !d_stall;
    assign accept  = mem_ok && (!q_full || q_pop) && !redirect;

    assign imem_addr = fetch_pc;
    assign q_count   = cnt;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic byp;

    // Empty queue: hand the fresh word straight to decode.
    assign byp  = q_empty && accept;
    assign push = accept && !(byp && !d_stall);

    always_comb begin
        d_valid = 1'b0;
        d_instr = '0;
        d_pc    = '0;
        if (byp) begin
            d_valid = 1'b1;
            d_instr = imem_data;
            d_pc    = fetch_pc;
        end else if (!q_empty) begin
            d_valid = 1'b1;
            d_instr = instr_mem[rd_ptr];
            d_pc    = pc_mem[rd_ptr];
        end
    end
`else
    assign push = accept;

    always_comb begin
        d_valid = 1'b0;
        d_instr = '0;
        d_pc    = '0;
        if (!q_empty) begin
            d_valid = 1'b1;
            d_instr = instr_mem[rd_ptr];
            d_pc    = pc_mem[rd_ptr];
        end
    end
`endif

    // Storage is never cleared; pointers alone decide visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
        end else if (redirect) begin
            // Any same-cycle pop already went to decode.
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (q_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(q_pop);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, DEPTH=4, RESET_PC=0x100).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_fetch_queue;

    localparam logic [31:0] RPC   = 32'h100;
    localparam logic [31:0] MAGIC = 32'hDEAD_0000;
    localparam logic [31:0] BAD   = 32'hBAD0_BAD0;

    logic        clock;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        d_stall;
    logic        d_valid;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [2:0]  q_count;
    logic        corrupt;

    int checks;
    int errors;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (RPC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_stall  (imem_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .d_stall     (d_stall),
        .d_valid     (d_valid),
        .d_instr     (d_instr),
        .d_pc        (d_pc),
        .q_count     (q_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: word is a fixed function of its address.
    always_comb begin
        imem_data = corrupt ? BAD : (imem_addr ^ MAGIC);
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        redirect   = 1'b0;
        imem_stall = 1'b0;
        d_stall    = 1'b0;
        corrupt    = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    int delivered;

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_stall  = 1'b0;
        d_stall     = 1'b0;
        corrupt     = 1'b0;
        @(negedge clock);
        @(negedge clock);

        // Reset state, sampled while reset still held.
        #1;
        chk("rst_addr",  imem_addr, RPC);
        chk("rst_valid", 32'(d_valid), 32'd0);
        chk("rst_instr", d_instr, 32'd0);
        chk("rst_pc",    d_pc, 32'd0);
        chk("rst_cnt",   32'(q_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Free-running stream: decode trails fetch by one cycle.
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("run_addr", imem_addr, RPC + 32'(4 * k));
            if (k == 0) begin
                chk("run_v0", 32'(d_valid), 32'd0);
                chk("run_c0", 32'(q_count), 32'd0);
            end else begin
                chk("run_pc",  d_pc, RPC + 32'(4 * (k - 1)));
                chk("run_cnt", 32'(q_count), 32'd1);
            end
            @(negedge clock);
        end

        // Decode stall fills the queue, then 16 push+pop cycles.
        do_reset();
        d_stall = 1'b1;
        for (int j = 0; j < 8; j++) begin
            int f;
            f = (j < 4) ? j : 4;
            #1;
            chk("full_cnt",  32'(q_count), 32'(f));
            chk("full_addr", imem_addr, RPC + 32'(4 * f));
            chk("full_pc",   d_pc, (j == 0) ? 32'd0 : RPC);
            @(negedge clock);
        end
        d_stall = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("drain_pc",    d_pc, RPC + 32'(4 * i));
            chk("drain_instr", d_instr, (RPC + 32'(4 * i)) ^ MAGIC);
            chk("drain_cnt",   32'(q_count), 32'd4);
            chk("drain_addr",  imem_addr, 32'h110 + 32'(4 * i));
            @(negedge clock);
        end

        // Redirect with three entries queued.
        do_reset();
        d_stall = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("redir_pre", 32'(q_count), 32'd3);
        redirect    = 1'b1;
        redirect_pc = 32'h2000;
        corrupt     = 1'b1;
        d_stall     = 1'b0;
        #1;
        chk("redir_pop", d_pc, RPC);
        @(negedge clock);
        redirect = 1'b0;
        corrupt  = 1'b0;
        #1;
        chk("redir_cnt",  32'(q_count), 32'd0);
        chk("redir_addr", imem_addr, 32'h2000);
        chk("redir_v",    32'(d_valid), 32'd0);
        @(negedge clock);
        #1;
        chk("redir_pc",    d_pc, 32'h2000);
        chk("redir_instr", d_instr, 32'h2000 ^ MAGIC);
        chk("redir_n",     32'(q_count), 32'd1);

        // Stall pattern 1,1,0,1,0 then held stalled.
        do_reset();
        delivered = 0;
        for (int c = 0; c < 7; c++) begin
            logic [4:0] pat;
            pat = 5'b01011;
            imem_stall = (c < 5) ? pat[c] : 1'b1;
            #1;
            if (d_valid) begin
                delivered++;
                chk("pat_pc", d_pc,
                    (c == 3) ? RPC : RPC + 32'd4);
            end else begin
                chk("pat_instr0", d_instr, 32'd0);
            end
            chk("pat_v", 32'(d_valid),
                (c == 3 || c == 5) ? 32'd1 : 32'd0);
            @(negedge clock);
        end
        chk("pat_count", 32'(delivered), 32'd2);

        // Reset beats a simultaneous redirect.
        imem_stall = 1'b0;
        d_stall    = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        chk("rr_pre", 32'(q_count), 32'd2);
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h3000;
        @(negedge clock);
        reset    = 1'b0;
        redirect = 1'b0;
        #1;
        chk("rr_addr",  imem_addr, RPC);
        chk("rr_valid", 32'(d_valid), 32'd0);
        chk("rr_instr", d_instr, 32'd0);
        chk("rr_pc",    d_pc, 32'd0);
        chk("rr_cnt",   32'(q_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised fetch unit with a decoupling instruction queue between the instruction memory controller and the decode stage. It owns the fetch PC, requests one 32-bit instruction per cycle from `instr_mem_ctrl`, and buffers up to `DEPTH` {pc, instr} pairs. Fetch therefore keeps running while decode is stalled, and a stalled instruction memory no longer freezes decode while buffered work remains. Branch and jump redirects from execute flush the queue and restart fetch at the target.

## Interface
- `DEPTH`, 4, queue entries; power of two, at least 2.
- `RESET_PC`, 32'h0000_0000, fetch PC after reset.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `imem_addr` output 32: fetch address to the instruction memory controller; always equals the fetch PC.
- `imem_data` input 32: instruction word for `imem_addr`; valid when `imem_stall`=0.
- `imem_stall` input 1: 1 means the instruction memory is not returning data this cycle. X is treated as 1.
- `redirect` input 1: taken branch or jump resolved in execute.
- `redirect_pc` input 32: target address; sampled when `redirect`=1.
- `d_stall` input 1: decode cannot accept an instruction this cycle.
- `d_valid` output 1: `d_instr`/`d_pc` hold a valid instruction.
- `d_instr` output 32: instruction to decode; 0 when `d_valid`=0.
- `d_pc` output 32: address of `d_instr`; 0 when `d_valid`=0.
- `q_count` output $clog2(DEPTH)+1: number of occupied entries.

## Operation
- Storage: circular buffer with `DEPTH` entries of {pc[31:0], instr[31:0]}. Read and write pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy counter runs 0..DEPTH.
- pop = `d_valid` & ~`d_stall`. The head entry is delivered to decode and removed.
- accept = ~`imem_stall` & (`q_count` < DEPTH | pop) & ~`redirect`.
  - On accept: push {`imem_addr`, `imem_data`} and set fetch PC to fetch PC + 4. Overflow wraps modulo 2^32.
- Full queue with no pop: fetch PC holds and `imem_data` is ignored.
- Full queue with pop: push and pop occur in the same cycle and `q_count` stays at DEPTH.
- Empty queue: `d_valid`=0. A pop is impossible.
- Redirect has priority over all other events:
  - Both pointers and the counter are cleared.
  - Fetch PC is set to `redirect_pc`.
  - The `imem_data` returned in that cycle is discarded.
  - A pop in the redirect cycle still completes. The instruction at the head was legally handed to decode, and flushing it is the hazard logic's job.
- Reset:
  - Fetch PC = `RESET_PC`, queue empty.
  - `d_valid`=0, `d_instr`=0, `d_pc`=0, `q_count`=0.
  - Reset dominates `redirect` and applies identically when asserted mid-operation.
- Queue contents are not cleared by flush or reset. Only the pointers and counter are, so stale entries are never visible.

## Timing
- Fetch PC to `imem_addr`: combinational, 0 cycles.
- Accept in cycle N: without bypass, `d_valid`=1 with that instruction in cycle N+1 at the earliest.
- Redirect in cycle N:
  - `imem_addr`=`redirect_pc` in N+1.
  - `q_count`=0 in N+1.
  - The first redirected instruction reaches decode no earlier than N+2, or N+1 with bypass.
- Throughput: one instruction per cycle sustained when `imem_stall`=0 and `d_stall`=0.
- `q_count` is registered and reflects the state after the previous edge.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When the queue is empty, the cycle accepts, and there is no redirect, `d_valid`/`d_instr`/`d_pc` are driven combinationally from `imem_data`/`imem_addr` in the same cycle.
  - If `d_stall`=0 in that cycle, the instruction is consumed without being written and `q_count` stays 0.
  - If `d_stall`=1, it is written into the queue as usual.
  - Fetch-to-decode latency becomes 0 cycles.
- Not defined: `d_*` are always driven from the queue head. Outputs depend only on registered state, and minimum latency is 1 cycle.

## Test plan
- Reset with `RESET_PC`=32'h100, `imem_stall`=0, `d_stall`=0 for 4 cycles -> `imem_addr` steps 100,104,108,10C; `d_pc` follows one cycle behind (same cycle with bypass); `q_count` ≤1.
- `d_stall`=1 for 8 cycles, DEPTH=4 -> `q_count` saturates at 4; `imem_addr` holds 32'h110; `d_pc` holds 32'h100 throughout; release delivers 100,104,108,10C,110 in consecutive cycles.
- Queue full with `d_stall` dropping in the same cycle `imem_stall`=0 -> simultaneous push and pop; `q_count` stays 4; no instruction is lost or duplicated across 16 cycles.
- `redirect`=1 with `redirect_pc`=32'h2000 while `q_count`=3 -> next cycle `q_count`=0 and `imem_addr`=32'h2000; the next `d_pc` seen is 32'h2000; the discarded `imem_data` never appears.
- `imem_stall` pattern 1,1,0,1,0 with `d_stall`=0 -> exactly two instructions are delivered, with consecutive PCs; `d_valid` is 0 while empty and `d_instr`=0 then.
- `reset` asserted with `q_count`=2 and `redirect`=1 in the same cycle -> next cycle `imem_addr`=`RESET_PC`, all outputs at reset values.
